quad_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 43 ++++
 rtl/quad_filter.sv | 42 ++++
 rtl/quad_decoder.sv | 93 +++++++++
 tb/tb_quad_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and Gray-step decode for the quadrature reader
package quad_pkg;

  typedef enum logic [1:0] {
    PH00 = 2'b00,
    PH01 = 2'b01,
    PH11 = 2'b11,
    PH10 = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } qstate_t;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } step_t;

  // Map {a,b} to its position in the up sequence (Gray-to-binary), then the
  // modulo-4 distance tells us up (1), down (3), illegal (2) or no change (0).
  function automatic step_t step_dir(input phase_t prev, input phase_t cur);
    logic [1:0] pb;
    logic [1:0] cb;
    logic [1:0] pi;
    logic [1:0] ci;
    logic [1:0] d;
    step_t      res;
    pb = prev;
    cb = cur;
    pi = {pb[1], pb[1] ^ pb[0]};
    ci = {cb[1], cb[1] ^ cb[0]};
    d  = ci - pi;
    res.valid   = (d == 2'd1) || (d == 2'd3);
    res.up      = (d == 2'd1);
    res.illegal = (d == 2'd2);
    return res;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - two-flop synchroniser plus consecutive-sample glitch filter
module quad_filter #(
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d_in,
  output logic d_out
);

  localparam int CW = $clog2(FILT + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_acc;
  logic [CW-1:0] r_cnt;

  // Any agreeing sample restarts the run, so only FILT consecutive
  // disagreeing samples move the accepted value.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_acc   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= d_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_acc) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT - 1)) begin
        r_acc <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign d_out = r_acc;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature A/B reader: filter, Gray decode, position counter
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             tc,
  output logic             err
);

  localparam int IW = $clog2(FILT + 3);

  logic             w_a_f;
  logic             w_b_f;
  phase_t           w_cur;
  step_t            w_sd;

  qstate_t          r_state;
  phase_t           r_ref;
  logic [IW-1:0]    r_init_cnt;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_step;
  logic             r_err;

  quad_filter #(.FILT(FILT)) u_filt_a (.clk(clk), .clr_n(clr_n), .d_in(a_in), .d_out(w_a_f));
  quad_filter #(.FILT(FILT)) u_filt_b (.clk(clk), .clr_n(clr_n), .d_in(b_in), .d_out(w_b_f));

  assign w_cur = phase_t'({w_a_f, w_b_f});
  assign w_sd  = step_dir(r_ref, w_cur);

  // INIT waits long enough for a phase present at reset release to pass the
  // synchroniser and filter, so the reference is loaded without a step.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= INIT;
      r_ref      <= PH00;
      r_init_cnt <= '0;
      r_count    <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        INIT: begin
          if (r_init_cnt == IW'(FILT + 2)) begin
            r_ref   <= w_cur;
            r_state <= TRACK;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        TRACK: begin
          if (w_sd.illegal) begin
            r_state <= FAULT;
            r_err   <= 1'b1;
          end else if (w_sd.valid) begin
            r_ref <= w_cur;
            if (en) begin
              r_step  <= 1'b1;
              r_dir   <= w_sd.up;
              r_count <= w_sd.up ? r_count + 1'b1 : r_count - 1'b1;
            end
          end
        end
        FAULT: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state <= FAULT;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign count = r_count;
  assign dir   = r_dir;
  assign step  = r_step;
  assign err   = r_err;
  assign tc    = r_dir ? (&r_count) : (r_count == '0);

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;

  localparam int WIDTH = 4;
  localparam int FILT  = 2;

  logic             clk   = 1'b0;
  logic             clr_n = 1'b0;
  logic             a_in  = 1'b0;
  logic             b_in  = 1'b0;
  logic             en    = 1'b1;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             tc;
  logic             err;

  int checks    = 0;
  int errors    = 0;
  int cur_idx   = 0;
  int exp_count = 0;
  int step_seen = 0;

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(WIDTH), .FILT(FILT)) dut (
    .clk(clk), .clr_n(clr_n), .a_in(a_in), .b_in(b_in), .en(en),
    .count(count), .dir(dir), .step(step), .tc(tc), .err(err)
  );

  function automatic logic [1:0] gray(input int idx);
    case (idx & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic set_idx(input int idx);
    cur_idx = idx & 3;
    {a_in, b_in} = gray(cur_idx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step === 1'b1) step_seen++;
    end
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    clr_n = 1'b0;
    set_idx(idx);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    step_seen = 0;
    idle(8);
    exp_count = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (count !== 4'd0 || dir !== 1'b0 || step !== 1'b0 || err !== 1'b0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals count=%0d dir=%b step=%b err=%b tc=%b want 0 0 0 0 1", count, dir, step, err, tc);
    end
    clr_n = 1'b1;
    step_seen = 0;
    idle(8);
    checks++;
    if (step_seen !== 0 || count !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_init steps=%0d count=%0d err=%b want 0 0 0", step_seen, count, err);
    end
  endtask

  task automatic test_up();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_idx(cur_idx + 1);
      repeat (4) @(negedge clk);
      checks++;
      if (step !== 1'b0 || count !== WIDTH'(exp_count)) begin
        errors++;
        $display("FAIL up_early i=%0d step=%b count=%0d want 0 %0d", i, step, count, exp_count);
      end
      exp_count = (exp_count + 1) % 16;
      @(negedge clk);
      if (step === 1'b1) pulses++;
      checks++;
      if (step !== 1'b1 || count !== WIDTH'(exp_count) || dir !== 1'b1) begin
        errors++;
        $display("FAIL up_step i=%0d step=%b count=%0d dir=%b want 1 %0d 1", i, step, count, dir, exp_count);
      end
      checks++;
      if (tc !== (exp_count == 15)) begin
        errors++;
        $display("FAIL up_tc count=%0d tc=%b want %b", count, tc, exp_count == 15);
      end
      repeat (2) begin
        @(negedge clk);
        if (step === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses !== 20) begin
      errors++;
      $display("FAIL up_pulses got=%0d want 20", pulses);
    end
  endtask

  task automatic test_down();
    do_reset(cur_idx);
    checks++;
    if (tc !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL down_start tc=%b count=%0d want 1 0", tc, count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idx(cur_idx + 3);
      repeat (4) @(negedge clk);
      exp_count = (exp_count + 15) % 16;
      @(negedge clk);
      checks++;
      if (step !== 1'b1 || count !== WIDTH'(exp_count) || dir !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL down_step i=%0d step=%b count=%0d dir=%b tc=%b want 1 %0d 0 0", i, step, count, dir, tc, exp_count);
      end
      idle(2);
    end
  endtask

  task automatic test_glitch();
    int n;
    logic [WIDTH-1:0] c1, c2;
    logic d1, d2;
    n = 0; c1 = '0; c2 = '0; d1 = 1'b0; d2 = 1'b0;
    @(negedge clk);
    set_idx(cur_idx + 3);
    exp_count = (exp_count + 15) % 16;
    idle(8);
    @(negedge clk);
    a_in = ~a_in;
    @(negedge clk);
    a_in = ~a_in;
    step_seen = 0;
    idle(10);
    checks++;
    if (step_seen !== 0 || count !== WIDTH'(exp_count)) begin
      errors++;
      $display("FAIL glitch_reject steps=%0d count=%0d want 0 %0d", step_seen, count, exp_count);
    end
    @(negedge clk);
    b_in = ~b_in;
    @(negedge clk);
    @(negedge clk);
    b_in = ~b_in;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        if (n == 0) begin c1 = count; d1 = dir; end
        else begin c2 = count; d2 = dir; end
        n++;
      end
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL pulse_steps got=%0d want 2", n);
    end
    checks++;
    if (c1 !== WIDTH'(exp_count + 1) || d1 !== 1'b1) begin
      errors++;
      $display("FAIL pulse_up count=%0d dir=%b want %0d 1", c1, d1, exp_count + 1);
    end
    checks++;
    if (c2 !== WIDTH'(exp_count) || d2 !== 1'b0) begin
      errors++;
      $display("FAIL pulse_down count=%0d dir=%b want %0d 0", c2, d2, exp_count);
    end
  endtask

  task automatic test_fault();
    @(negedge clk);
    a_in = ~a_in;
    b_in = ~b_in;
    cur_idx = cur_idx + 2;
    step_seen = 0;
    idle(8);
    checks++;
    if (err !== 1'b1 || count !== WIDTH'(exp_count) || step_seen !== 0) begin
      errors++;
      $display("FAIL fault_enter err=%b count=%0d steps=%0d want 1 %0d 0", err, count, step_seen, exp_count);
    end
    @(negedge clk);
    set_idx(cur_idx + 1);
    idle(8);
    checks++;
    if (err !== 1'b1 || count !== WIDTH'(exp_count) || step_seen !== 0) begin
      errors++;
      $display("FAIL fault_frozen err=%b count=%0d steps=%0d want 1 %0d 0", err, count, step_seen, exp_count);
    end
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL fault_clear err=%b count=%0d want 0 0", err, count);
    end
    @(negedge clk);
    clr_n = 1'b1;
    step_seen = 0;
    exp_count = 0;
    idle(8);
    checks++;
    if (err !== 1'b0 || count !== 4'd0 || step_seen !== 0) begin
      errors++;
      $display("FAIL fault_reacq err=%b count=%0d steps=%0d want 0 0 0", err, count, step_seen);
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    step_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idx(cur_idx + 1);
      idle(8);
    end
    checks++;
    if (step_seen !== 0 || count !== 4'd0 || dir !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL en_hold steps=%0d count=%0d dir=%b err=%b want 0 0 0 0", step_seen, count, dir, err);
    end
    en = 1'b1;
    @(negedge clk);
    set_idx(cur_idx + 1);
    idle(8);
    checks++;
    if (step_seen !== 1 || count !== 4'd1 || dir !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL en_resume steps=%0d count=%0d dir=%b err=%b want 1 1 1 0", step_seen, count, dir, err);
    end
  endtask

  task automatic test_clear();
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_idx(cur_idx + 1);
      idle(8);
    end
    checks++;
    if (count !== 4'd9 || {a_in, b_in} !== 2'b11) begin
      errors++;
      $display("FAIL clr_setup count=%0d ab=%b want 9 11", count, {a_in, b_in});
    end
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || dir !== 1'b0 || step !== 1'b0 || err !== 1'b0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL clr_vals count=%0d dir=%b step=%b err=%b tc=%b want 0 0 0 0 1", count, dir, step, err, tc);
    end
    @(negedge clk);
    clr_n = 1'b1;
    step_seen = 0;
    idle(10);
    checks++;
    if (step_seen !== 0 || count !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clr_reacq steps=%0d count=%0d err=%b want 0 0 0", step_seen, count, err);
    end
    @(negedge clk);
    set_idx(3);
    idle(8);
    checks++;
    if (step_seen !== 1 || count !== 4'd1 || dir !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL clr_next steps=%0d count=%0d dir=%b err=%b want 1 1 1 0", step_seen, count, dir, err);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_glitch();
    test_fault();
    test_enable();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
